// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the store buffer: DMCtrl encodings, the access-size
//   helper, and the layout of one buffered store entry.
package store_buffer_pkg;

    // DMCtrl encodings as seen on the core and DM ports.
    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    // Widest address an entry can hold; the buffer's AW must not exceed it.
    localparam int SB_AW = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [31:0]      wdata;
        logic [1:0]       ctrl;   // size only; signedness is irrelevant to stores
    } sb_entry_t;

    // Access length in bytes. 2'b11 never reaches a stored entry; it is treated
    // as a word so a malformed load overlaps conservatively.
    function automatic logic [2:0] size_bytes(input logic [1:0] ctrl);
        case (ctrl)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Store encodings that carry a real size: rejects 011, 110 and 111.
    function automatic logic store_ctrl_ok(input logic [2:0] ctrl);
        return (ctrl[1:0] != 2'b11) && (ctrl[2:1] != 2'b11);
    endfunction

endpackage

// File: rtl/sb_overlap_chk.sv
// sb_overlap_chk
//   Compares one buffered store entry against the current load request.
//   Ports:
//     entry_valid / entry_addr / entry_ctrl : the buffered store
//     load_addr / load_ctrl                 : the load request (size bits only)
//     overlap : byte ranges intersect (entry must be valid)
//     exact   : overlap with identical address and size, so data can forward
module sb_overlap_chk
    import store_buffer_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          entry_valid,
    input  logic [AW-1:0] entry_addr,
    input  logic [1:0]    entry_ctrl,
    input  logic [AW-1:0] load_addr,
    input  logic [1:0]    load_ctrl,
    output logic          overlap,
    output logic          exact
);

    // Range ends are one bit wider so an access at the top of the address
    // space cannot wrap around and look like it overlaps address 0.
    logic [AW:0] entry_end;
    logic [AW:0] load_end;

    assign entry_end = {1'b0, entry_addr} + (AW+1)'(size_bytes(entry_ctrl));
    assign load_end  = {1'b0, load_addr}  + (AW+1)'(size_bytes(load_ctrl));

    assign overlap = entry_valid
                  && ({1'b0, entry_addr} < load_end)
                  && ({1'b0, load_addr}  < entry_end);

    assign exact = overlap && (entry_addr == load_addr) && (entry_ctrl == load_ctrl);

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   In-order store buffer between the core memory stage and the data memory.
//   Stores queue up and drain to DM one per cycle when the port is free; loads
//   own the port first, forward from an exactly matching youngest store, and
//   stall on a partial overlap.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     req_valid/wr/addr/wdata/ctrl  : core request (held by the core while stall)
//     stall                         : core must hold its request
//     rdata                         : load result when the load is not stalled
//     dm_addr/wdata/wr/ctrl         : DM request
//     dm_rdata, dm_ready            : DM read data, DM write acceptance
//     fence                         : stall until every pending store is written
//     empty, count                  : occupancy
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_wr,
    input  logic [AW-1:0]            req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [2:0]               req_ctrl,
    output logic                     stall,
    output logic [31:0]              rdata,
    output logic [AW-1:0]            dm_addr,
    output logic [31:0]              dm_wdata,
    output logic                     dm_wr,
    output logic [2:0]               dm_ctrl,
    input  logic [31:0]              dm_rdata,
    input  logic                     dm_ready,
    input  logic                     fence,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic [DEPTH-1:0] ovl;
    logic [DEPTH-1:0] exa;
    logic             hit;
    logic             hit_exact;
    logic [31:0]      hit_wdata;
    logic [31:0]      fwd_data;
    sb_entry_t        head;

    logic load, store_req, full, fence_block, stall_int;
    logic load_port, drain, push, pop;

    for (genvar i = 0; i < DEPTH; i++) begin : g_chk
        sb_overlap_chk #(.AW(AW)) u_chk (
            .entry_valid (valid_q[i]),
            .entry_addr  (AW'(entries[i].addr)),
            .entry_ctrl  (entries[i].ctrl),
            .load_addr   (req_addr),
            .load_ctrl   (req_ctrl[1:0]),
            .overlap     (ovl[i]),
            .exact       (exa[i])
        );
    end

    // Walk entries from oldest to youngest so the last overlapping one wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        hit       = 1'b0;
        hit_exact = 1'b0;
        hit_wdata = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ovl[tail_q - PW'(k)]) begin
                hit       = 1'b1;
                hit_exact = exa[tail_q - PW'(k)];
                hit_wdata = entries[tail_q - PW'(k)].wdata;
            end
        end
    end

    // Forwarded data is resized by the load's own encoding; size already matches.
    always_comb begin
        fwd_data = hit_wdata;
        case (req_ctrl[1:0])
            2'b00:   fwd_data = req_ctrl[2] ? {24'b0, hit_wdata[7:0]}
                                            : {{24{hit_wdata[7]}}, hit_wdata[7:0]};
            2'b01:   fwd_data = req_ctrl[2] ? {16'b0, hit_wdata[15:0]}
                                            : {{16{hit_wdata[15]}}, hit_wdata[15:0]};
            default: fwd_data = hit_wdata;
        endcase
    end

    assign load        = req_valid && !req_wr;
    assign store_req   = req_valid && req_wr && store_ctrl_ok(req_ctrl);
    assign full        = (count_q == CW'(DEPTH));
    assign fence_block = fence && (count_q != '0);
    assign stall_int   = fence_block || (store_req && full) || (load && hit && !hit_exact);

    // A fenced load leaves the port to the drain, otherwise the fence could
    // never complete.
    assign load_port = load && !hit && !fence_block;
    assign drain     = !rst && (count_q != '0) && !load_port;
    assign push      = !rst && store_req && !stall_int;
    assign pop       = drain && dm_ready;

    assign head     = entries[head_q];
    assign stall    = !rst && stall_int;
    assign rdata    = hit_exact ? fwd_data : dm_rdata;
    assign dm_wr    = drain;
    assign dm_addr  = load_port ? req_addr : AW'(head.addr);
    assign dm_wdata = head.wdata;
    assign dm_ctrl  = load_port ? req_ctrl : {1'b0, head.ctrl};
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // NOTE: the entry storage has no reset; valid_q and the pointers alone
    // decide what is live, so stale payloads are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_q] <= '{addr: SB_AW'(req_addr), wdata: req_wdata, ctrl: req_ctrl[1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Push only happens when not full, so it never targets the head slot
            // while that slot is being popped.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = 3;

    logic          clk, rst;
    logic          req_valid, req_wr;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_ctrl;
    logic          stall;
    logic [31:0]   rdata;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_wr;
    logic [2:0]    dm_ctrl;
    logic [31:0]   dm_rdata;
    logic          dm_ready;
    logic          fence;
    logic          empty;
    logic [CW-1:0] count;

    int tests_run    = 0;
    int tests_failed = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .stall(stall), .rdata(rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr(dm_wr), .dm_ctrl(dm_ctrl),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .fence(fence), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory model (byte array, little-endian) ----------
    logic [7:0] dm_mem [64];
    int         dm_writes = 0;

    function automatic int nbytes(input logic [2:0] c);
        case (c[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] c);
        case (c)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'b0, raw[7:0]};
            3'b101:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        if (dm_wr && dm_ready) begin
            for (int i = 0; i < nbytes(dm_ctrl); i++)
                dm_mem[6'(dm_addr + AW'(i))] <= dm_wdata[8*i +: 8];
            dm_writes <= dm_writes + 1;
        end
    end

    always_comb begin
        dm_rdata = extend({dm_mem[6'(dm_addr + 32'd3)], dm_mem[6'(dm_addr + 32'd2)],
                           dm_mem[6'(dm_addr + 32'd1)], dm_mem[6'(dm_addr)]}, dm_ctrl);
    end

    // ---------------- reference model: pending stores in program order -------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } st_t;
    st_t q[$];

    // Architectural view: DM contents with every pending store applied in order.
    function automatic logic [31:0] arch_read(input logic [31:0] a, input logic [2:0] c);
        logic [7:0] img [64];
        img = dm_mem;
        foreach (q[i])
            for (int b = 0; b < nbytes(q[i].ctrl); b++)
                img[6'(q[i].addr + 32'(b))] = q[i].data[8*b +: 8];
        return extend({img[6'(a + 32'd3)], img[6'(a + 32'd2)], img[6'(a + 32'd1)], img[6'(a)]}, c);
    endfunction

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        req_ctrl  = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        idle();
        dm_ready = 1'b1;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        @(negedge clk);
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_timeout: count=%0d required empty", count); end
        tick();
    endtask

    // ---------------- directed tests ----------------------------------------
    task automatic test_reset();
        rst = 1'b1; fence = 1'b1; dm_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h20, 32'hAA, 3'b010);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b required 0", stall); end
        tests_run++; if (dm_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_dm_wr: got %b required 0", dm_wr); end
        tick(); tick();
        rst = 1'b0; fence = 1'b0; idle();
        @(negedge clk);
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d required 0", count); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b required 1", empty); end
        tests_run++; if (dm_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_wr: got %b required 0", dm_wr); end
        tick();
    endtask

    task automatic test_drain_latency();
        dm_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL sw_stall: got %b required 0", stall); end
        tick();
        idle();
        @(negedge clk);
        tests_run++; if (dm_wr !== 1'b1) begin tests_failed++; $display("FAIL lat_dm_wr: got %b required 1", dm_wr); end
        tests_run++; if (dm_addr !== 32'h10) begin tests_failed++; $display("FAIL lat_dm_addr: got %h required 00000010", dm_addr); end
        tests_run++; if (dm_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lat_dm_wdata: got %h required deadbeef", dm_wdata); end
        tests_run++; if (dm_ctrl !== 3'b010) begin tests_failed++; $display("FAIL lat_dm_ctrl: got %b required 010", dm_ctrl); end
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL lat_count: got %0d required 1", count); end
        tick();
        @(negedge clk);
        tests_run++; if (empty !== 1'b1 || count !== 3'd0) begin tests_failed++; $display("FAIL lat_empty: got empty=%b count=%0d required 1/0", empty, count); end
        tests_run++; if (dm_wr !== 1'b0) begin tests_failed++; $display("FAIL lat_idle_wr: got %b required 0", dm_wr); end
        tick();
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_a [3];
        logic [31:0] exp_d [3];
        exp_a = '{32'h08, 32'h0C, 32'h14};
        exp_d = '{32'hA2, 32'hA3, 32'hA4};
        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(4*i), 32'hA0 + 32'(i), 3'b010);
            tick();
        end
        drive(1'b1, 1'b1, 32'h14, 32'hA4, 3'b010);
        @(negedge clk);
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d required 4", count); end
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL full_stall: got %b required 1", stall); end
        tests_run++; if (dm_wr !== 1'b1 || dm_addr !== 32'h0) begin tests_failed++; $display("FAIL full_head: got wr=%b addr=%h required 1/00000000", dm_wr, dm_addr); end
        tick();
        dm_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL full_no_bypass: got %b required 1", stall); end
        tick();
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || count !== 3'd3) begin tests_failed++; $display("FAIL full_after_pop: got stall=%b count=%0d required 0/3", stall, count); end
        tests_run++; if (dm_addr !== 32'h04) begin tests_failed++; $display("FAIL full_order1: got %h required 00000004", dm_addr); end
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            tests_run++;
            if (dm_wr !== 1'b1 || dm_addr !== exp_a[j] || dm_wdata !== exp_d[j]) begin
                tests_failed++;
                $display("FAIL full_order%0d: got wr=%b addr=%h data=%h required 1/%h/%h", j + 2, dm_wr, dm_addr, dm_wdata, exp_a[j], exp_d[j]);
            end
            tick();
        end
        @(negedge clk);
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL full_drained: count=%0d required 0", count); end
        tick();
    endtask

    task automatic test_forward();
        dm_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h04, 32'h80, 3'b000);
        tick();
        drive(1'b1, 1'b0, 32'h04, 32'h0, 3'b000);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || rdata !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL fwd_lb: got stall=%b rdata=%h required 0/ffffff80", stall, rdata); end
        tick();
        drive(1'b1, 1'b0, 32'h04, 32'h0, 3'b100);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || rdata !== 32'h00000080) begin tests_failed++; $display("FAIL fwd_lbu: got stall=%b rdata=%h required 0/00000080", stall, rdata); end
        tick();
        drive(1'b1, 1'b0, 32'h04, 32'h0, 3'b001);
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL fwd_size_mismatch: got stall=%b required 1", stall); end
        tick();
        drive(1'b1, 1'b0, 32'h05, 32'h0, 3'b000);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 32'h05) begin tests_failed++; $display("FAIL fwd_adjacent: got stall=%b wr=%b addr=%h required 0/0/00000005", stall, dm_wr, dm_addr); end
        tick();
        drain_all();
    endtask

    task automatic test_partial();
        dm_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h08, 32'h11223344, 3'b010);
        tick();
        drive(1'b1, 1'b0, 32'h09, 32'h0, 3'b000);
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL partial_stall: got %b required 1", stall); end
        tick();
        dm_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (stall !== 1'b1 || dm_wr !== 1'b1) begin tests_failed++; $display("FAIL partial_drain: got stall=%b wr=%b required 1/1", stall, dm_wr); end
        tick();
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || rdata !== 32'h33) begin tests_failed++; $display("FAIL partial_release: got stall=%b rdata=%h required 0/00000033", stall, rdata); end
        tests_run++; if (dm_wr !== 1'b0) begin tests_failed++; $display("FAIL partial_port: got wr=%b required 0", dm_wr); end
        tick();
        idle();
    endtask

    task automatic test_youngest();
        dm_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0C, 32'h1111, 3'b001);
        tick();
        drive(1'b1, 1'b1, 32'h0C, 32'h2222, 3'b001);
        tick();
        drive(1'b1, 1'b0, 32'h0C, 32'h0, 3'b101);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || rdata !== 32'h2222) begin tests_failed++; $display("FAIL youngest: got stall=%b rdata=%h required 0/00002222", stall, rdata); end
        tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL youngest_count: got %0d required 2", count); end
        tick();
        drain_all();
    endtask

    task automatic test_invalid_and_fence();
        dm_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h20, 32'h55, 3'b011);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL invalid_stall: got %b required 0", stall); end
        tick();
        idle();
        @(negedge clk);
        tests_run++; if (count !== 3'd0 || dm_wr !== 1'b0) begin tests_failed++; $display("FAIL invalid_dropped: got count=%0d wr=%b required 0/0", count, dm_wr); end
        tick();
        dm_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h18, 32'h77, 3'b010);
        tick();
        idle();
        fence = 1'b1;
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL fence_stall: got %b required 1", stall); end
        tick();
        dm_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL fence_hold: got %b required 1", stall); end
        tick();
        @(negedge clk);
        tests_run++; if (stall !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL fence_release: got stall=%b count=%0d required 0/0", stall, count); end
        fence = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_queue();
        int w0;
        dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h30 + 32'(4*i), 32'hC0 + 32'(i), 3'b010);
            tick();
        end
        idle();
        @(negedge clk);
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL rstq_count: got %0d required 3", count); end
        tick();
        rst = 1'b1; fence = 1'b1; dm_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (dm_wr !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL rstq_during: got wr=%b stall=%b required 0/0", dm_wr, stall); end
        w0 = dm_writes;
        tick();
        rst = 1'b0; fence = 1'b0;
        @(negedge clk);
        tests_run++; if (count !== 3'd0 || empty !== 1'b1 || dm_wr !== 1'b0) begin tests_failed++; $display("FAIL rstq_after: got count=%0d empty=%b wr=%b required 0/1/0", count, empty, dm_wr); end
        repeat (5) tick();
        tests_run++; if (dm_writes !== w0) begin tests_failed++; $display("FAIL rstq_no_write: got %0d writes required %0d", dm_writes, w0); end
    endtask

    // ---------------- randomized test against the reference model -----------
    task automatic test_random(input int n);
        logic        hold, is_load, is_store, exp_stall, load_port, exp_wr, fenced, exact;
        logic [2:0]  lc [5];
        int          ovl;
        lc = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        hold = 1'b0;
        rst = 1'b1; idle(); fence = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < n; c++) begin
            if (!hold) begin
                fence = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) idle();
                else if ($urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 7))
                        0, 1:    req_ctrl = 3'b000;
                        2, 3:    req_ctrl = 3'b001;
                        4, 5, 6: req_ctrl = 3'b010;
                        default: req_ctrl = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b110;
                    endcase
                    drive(1'b1, 1'b1, 32'($urandom_range(0, 31)), $urandom, req_ctrl);
                end else begin
                    drive(1'b1, 1'b0, 32'($urandom_range(0, 31)), 32'h0, lc[$urandom_range(0, 4)]);
                end
            end
            dm_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            is_load  = req_valid && !req_wr;
            is_store = req_valid && req_wr && !(req_ctrl inside {3'b011, 3'b110, 3'b111});
            fenced   = fence && (q.size() > 0);
            ovl = -1;
            foreach (q[i])
                if (int'(q[i].addr) < int'(req_addr) + nbytes(req_ctrl) &&
                    int'(req_addr) < int'(q[i].addr) + nbytes(q[i].ctrl)) ovl = i;
            exact = (ovl >= 0) && (q[ovl].addr == req_addr) && (q[ovl].ctrl[1:0] == req_ctrl[1:0]);
            exp_stall = fenced || (is_store && q.size() == DEPTH) || (is_load && ovl >= 0 && !exact);
            load_port = is_load && ovl < 0 && !fenced;
            exp_wr    = (q.size() > 0) && !load_port;

            tests_run++; if (count !== CW'(q.size())) begin tests_failed++; $display("FAIL rnd_count c=%0d: got %0d required %0d", c, count, q.size()); end
            tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall c=%0d: got %b required %b", c, stall, exp_stall); end
            tests_run++; if (dm_wr !== exp_wr) begin tests_failed++; $display("FAIL rnd_dm_wr c=%0d: got %b required %b", c, dm_wr, exp_wr); end
            if (exp_wr) begin
                tests_run++;
                if (dm_addr !== q[0].addr || dm_wdata !== q[0].data || dm_ctrl !== {1'b0, q[0].ctrl[1:0]}) begin
                    tests_failed++;
                    $display("FAIL rnd_drain c=%0d: got %h/%h/%b required %h/%h/%b", c, dm_addr, dm_wdata, dm_ctrl, q[0].addr, q[0].data, {1'b0, q[0].ctrl[1:0]});
                end
            end
            if (is_load && !exp_stall) begin
                tests_run++;
                if (rdata !== arch_read(req_addr, req_ctrl)) begin
                    tests_failed++;
                    $display("FAIL rnd_load c=%0d: addr=%h ctrl=%b got %h required %h", c, req_addr, req_ctrl, rdata, arch_read(req_addr, req_ctrl));
                end
            end
            hold = exp_stall;

            @(posedge clk);
            if (exp_wr && dm_ready) void'(q.pop_front());
            if (is_store && !exp_stall) q.push_back('{addr: req_addr, data: req_wdata, ctrl: req_ctrl});
            #1;
        end
        fence = 1'b0;
        drain_all();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dm_mem[i] = 8'h00;
        rst = 1'b1; fence = 1'b0; dm_ready = 1'b1;
        idle();
        test_reset();
        test_drain_latency();
        test_full_stall();
        test_forward();
        test_partial();
        test_youngest();
        test_invalid_and_fence();
        test_reset_mid_queue();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
